cs_game_sequencer: RTL and testbench
====================================

CS_GAME_SEQUENCER -- requirements
Module: cs_game_sequencer

Interface
REQ-001 SHALL have parameter GAME_SECONDS, default 8'h99, BCD game-time reload value.
REQ-002 SHALL have parameter FRAMES_PER_SEC, default 60, frames per timer second.
REQ-003 SHALL have parameter MAX_CREDITS, default 9, credit saturation value.
REQ-004 SHALL have parameter OVER_FRAMES, default 180, GAME_OVER hold length.
REQ-005 SHALL have ports:
- clk_i  in  1  game clock; one clock only.
- res_n_i  in  1  reset, asynchronous, active-low.
- vsync  in  1  raw vertical sync level.
- coin  in  1  debounced coin level.
- start  in  1  debounced start level.
- hit_player  in  1  one-cycle pulse: player scored.
- hit_saucer  in  1  one-cycle pulse: saucer scored.
- game_active  out  1  play in progress.
- credits  out  4  binary credit count.
- time_bcd  out  8  remaining seconds, BCD.
- score_player  out  4  BCD 0-9.
- score_saucer  out  4  BCD 0-9.
- extended  out  1  extended play granted.
- invert  out  1  reverse-video request.

Function
REQ-006 SHALL derive frame_tick as a one-cycle pulse on vsync rising edge (vsync registered once, compared with current).
REQ-007 SHALL use states ATTRACT, PLAY, GAME_OVER.
REQ-008 SHALL increment credits on coin rising edge, saturating at MAX_CREDITS, in every state.
REQ-009 ATTRACT -> PLAY on start rising edge with credits>0: credits-1, scores 0, time_bcd=GAME_SECONDS, extended=0, frame count 0.
REQ-010 Coin edge and start edge in the same cycle SHALL net credits unchanged and still start when credits was 0 before the coin.
REQ-011 In PLAY, a frame counter SHALL count frame_ticks 0..FRAMES_PER_SEC-1; wrap SHALL decrement time_bcd by one BCD count (10 -> 09, 00 never decremented).
REQ-012 hit_player/hit_saucer SHALL increment the respective BCD score only in PLAY, wrapping 9 -> 0; simultaneous pulses SHALL both count.
REQ-013 time_bcd reaching 00 SHALL: if score_player > score_saucer and extended=0, reload GAME_SECONDS and set extended=1 in the same cycle; else enter GAME_OVER.
REQ-014 invert SHALL be 1 in PLAY whenever extended=1 and time_bcd is odd; 0 otherwise.
REQ-015 GAME_OVER SHALL hold scores, count OVER_FRAMES frame_ticks, then enter ATTRACT; start is ignored in GAME_OVER.
REQ-016 game_active SHALL equal (state==PLAY), registered.
REQ-017 Latency: all outputs registered; a score pulse appears on score_* one cycle later.

Reset
REQ-018 res_n_i low SHALL asynchronously force ATTRACT, credits=0, time_bcd=8'h00, scores=0, extended=0, invert=0, game_active=0, edge registers=0.
REQ-019 Reset asserted mid-PLAY SHALL discard the game and credits; release SHALL resume in ATTRACT with no spurious edge from a high coin/start/vsync level.

Configuration
REQ-020 With CS_FREEPLAY_EN defined, start SHALL enter PLAY regardless of credits and credits SHALL not decrement; without it, REQ-009 applies unchanged.

Structure
REQ-021 Package cs_game_pkg SHALL hold the state enum, BCD digit typedef and default parameter constants.
REQ-022 A sub-module cs_bcd_timer SHALL implement the two-digit BCD load/decrement/zero-flag counter.

Verification
REQ-023 Reset, coin x11 -> credits=9 (saturated), state ATTRACT.
REQ-024 credits=1, start edge -> game_active=1 next cycle, credits=0, time_bcd=99; 60 frame_ticks -> time_bcd=98.
REQ-025 time_bcd=10, 60 frame_ticks -> 09; at 00 with scores 3/5 -> GAME_OVER, 180 frames -> ATTRACT.
REQ-026 Scores 6/2 at 00 -> time_bcd=99, extended=1, invert toggles each second; next 00 -> GAME_OVER.
REQ-027 Simultaneous hit_player/hit_saucer at 9/9 -> both 0; reset mid-PLAY with coin held high -> credits=0, no increment after release.

Source files
------------

// File: rtl/cs_game_pkg.sv
// -----------------------------------------------------------------------------
// cs_game_pkg
// Shared types and default constants for the game sequencer.
//   game_state_e : top-level sequencer states
//   bcd_digit_t  : one BCD digit (0-9)
//   DEF_*        : default values for the sequencer parameters
//   bcd_inc()    : single-digit BCD increment that wraps 9 -> 0
// -----------------------------------------------------------------------------
package cs_game_pkg;

    typedef enum logic [1:0] {
        ST_ATTRACT   = 2'd0,
        ST_PLAY      = 2'd1,
        ST_GAME_OVER = 2'd2
    } game_state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [7:0] DEF_GAME_SECONDS   = 8'h99;
    localparam int         DEF_FRAMES_PER_SEC = 60;
    localparam int         DEF_MAX_CREDITS    = 9;
    localparam int         DEF_OVER_FRAMES    = 180;

    function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/cs_bcd_timer.sv
// -----------------------------------------------------------------------------
// cs_bcd_timer
// Two-digit BCD down counter with load, decrement and zero flag.
// Load has priority over decrement; 00 is never decremented.
// Ports:
//   clk_i, res_n_i : clock, asynchronous active-low reset (clears to 00)
//   load           : load load_value on the next edge
//   load_value     : BCD value to load
//   dec            : decrement by one BCD count on the next edge
//   value          : registered BCD count
//   value_nxt      : value the counter takes on the next edge
//   zero           : value == 00
// -----------------------------------------------------------------------------
module cs_bcd_timer
    import cs_game_pkg::*;
(
    input  logic       clk_i,
    input  logic       res_n_i,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       dec,
    output logic [7:0] value,
    output logic [7:0] value_nxt,
    output logic       zero
);

    bcd_digit_t tens;
    bcd_digit_t ones;

    assign tens = value[7:4];
    assign ones = value[3:0];
    assign zero = (value == 8'h00);

    always_comb begin
        // NOTE: default assignment first so every path drives value_nxt and no latch is inferred.
        value_nxt = value;
        if (load) begin
            value_nxt = load_value;
        end else if (dec && !zero) begin
            if (ones == 4'd0) value_nxt = {tens - 4'd1, 4'd9};
            else              value_nxt = {tens, ones - 4'd1};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) value <= 8'h00;
        else          value <= value_nxt;
    end

endmodule

// File: rtl/cs_game_sequencer.sv
// -----------------------------------------------------------------------------
// cs_game_sequencer
// Coin-op game sequencer: credits, attract/play/game-over flow, BCD game
// timer driven by vertical sync, BCD scores, one extended-play round and a
// reverse-video request during extended play.
// Optional feature: define CS_FREEPLAY_EN to start without credits and never
// consume credits.
// Ports:
//   clk_i, res_n_i           : game clock, asynchronous active-low reset
//   vsync, coin, start       : raw/debounced levels, rising edges are used
//   hit_player, hit_saucer   : one-cycle score pulses (counted only in PLAY)
//   game_active              : registered (state == PLAY)
//   credits                  : binary credit count, saturating
//   time_bcd                 : remaining seconds, BCD
//   score_player/saucer      : BCD score digits
//   extended                 : extended play granted this game
//   invert                   : reverse-video request
// -----------------------------------------------------------------------------
module cs_game_sequencer
    import cs_game_pkg::*;
#(
    parameter logic [7:0] GAME_SECONDS   = DEF_GAME_SECONDS,
    parameter int         FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
    parameter int         MAX_CREDITS    = DEF_MAX_CREDITS,
    parameter int         OVER_FRAMES    = DEF_OVER_FRAMES
)(
    input  logic       clk_i,
    input  logic       res_n_i,
    input  logic       vsync,
    input  logic       coin,
    input  logic       start,
    input  logic       hit_player,
    input  logic       hit_saucer,
    output logic       game_active,
    output logic [3:0] credits,
    output logic [7:0] time_bcd,
    output logic [3:0] score_player,
    output logic [3:0] score_saucer,
    output logic       extended,
    output logic       invert
);

    localparam int CNT_MAX = (FRAMES_PER_SEC > OVER_FRAMES) ? FRAMES_PER_SEC : OVER_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SEC_LAST   = CNT_W'(FRAMES_PER_SEC - 1);
    localparam logic [CNT_W-1:0] OVER_LAST  = CNT_W'(OVER_FRAMES - 1);
    localparam logic [3:0]       CREDIT_CAP = 4'(MAX_CREDITS);

    game_state_e      state;
    logic [CNT_W-1:0] frame_cnt;

    logic vsync_q, coin_q, start_q;
    logic armed;
    logic frame_tick, coin_edge, start_edge;
    logic start_go, credit_take;
    logic time_zero, sec_wrap, extend_go, play_end;
    logic [7:0] time_nxt;

    // Edge registers clear in reset; 'armed' suppresses edges during the first
    // cycle after release so a level already high is not seen as a new edge.
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            vsync_q <= 1'b0;
            coin_q  <= 1'b0;
            start_q <= 1'b0;
            armed   <= 1'b0;
        end else begin
            vsync_q <= vsync;
            coin_q  <= coin;
            start_q <= start;
            armed   <= 1'b1;
        end
    end

    assign frame_tick = armed && vsync && !vsync_q;
    assign coin_edge  = armed && coin  && !coin_q;
    assign start_edge = armed && start && !start_q;

`ifdef CS_FREEPLAY_EN
    assign start_go    = (state == ST_ATTRACT) && start_edge;
    assign credit_take = 1'b0;
`else
    // A coin arriving with the start edge counts toward starting the game.
    assign start_go    = (state == ST_ATTRACT) && start_edge && ((credits != 4'd0) || coin_edge);
    assign credit_take = start_go;
`endif

    assign sec_wrap  = (state == ST_PLAY) && frame_tick && (frame_cnt == SEC_LAST);
    assign extend_go = (state == ST_PLAY) && time_zero && (score_player > score_saucer) && !extended;
    assign play_end  = (state == ST_PLAY) && time_zero && !extend_go;

    cs_bcd_timer u_timer (
        .clk_i      (clk_i),
        .res_n_i    (res_n_i),
        .load       (start_go || extend_go),
        .load_value (GAME_SECONDS),
        .dec        (sec_wrap),
        .value      (time_bcd),
        .value_nxt  (time_nxt),
        .zero       (time_zero)
    );

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            state        <= ST_ATTRACT;
            frame_cnt    <= '0;
            credits      <= 4'd0;
            score_player <= 4'd0;
            score_saucer <= 4'd0;
            extended     <= 1'b0;
            invert       <= 1'b0;
            game_active  <= 1'b0;
        end else begin
            // Coin and start in the same cycle cancel out on the credit count.
            if (coin_edge && !credit_take) begin
                if (credits < CREDIT_CAP) credits <= credits + 4'd1;
            end else if (credit_take && !coin_edge) begin
                credits <= credits - 4'd1;
            end

            case (state)
                ST_ATTRACT: begin
                    if (start_go) begin
                        state        <= ST_PLAY;
                        game_active  <= 1'b1;
                        score_player <= 4'd0;
                        score_saucer <= 4'd0;
                        extended     <= 1'b0;
                        frame_cnt    <= '0;
                    end
                end
                ST_PLAY: begin
                    if (hit_player) score_player <= bcd_inc(score_player);
                    if (hit_saucer) score_saucer <= bcd_inc(score_saucer);
                    if (frame_tick) frame_cnt <= (frame_cnt == SEC_LAST) ? '0 : frame_cnt + 1'b1;
                    if (extend_go)  extended <= 1'b1;
                    if (play_end) begin
                        state       <= ST_GAME_OVER;
                        game_active <= 1'b0;
                        frame_cnt   <= '0;
                    end
                end
                ST_GAME_OVER: begin
                    if (frame_tick) begin
                        if (frame_cnt == OVER_LAST) begin
                            state     <= ST_ATTRACT;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= ST_ATTRACT;
                    game_active <= 1'b0;
                end
            endcase

            // Computed from next-cycle values so invert lines up with time_bcd.
            invert <= (state == ST_PLAY) && !play_end && (extended || extend_go) && time_nxt[0];
        end
    end

endmodule

// File: tb/tb_cs_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cs_game_sequencer
// Directed bench for cs_game_sequencer with default parameters
// (99 s game, 60 frames/s, 9 credits max, 180 game-over frames).
// Inputs change on the falling clock edge; outputs are sampled there too.
// One frame = vsync high for one cycle, then low for one cycle.
// -----------------------------------------------------------------------------
module tb_cs_game_sequencer;

    logic       clk_i      = 1'b0;
    logic       res_n_i    = 1'b0;
    logic       vsync      = 1'b0;
    logic       coin       = 1'b0;
    logic       start      = 1'b0;
    logic       hit_player = 1'b0;
    logic       hit_saucer = 1'b0;
    logic       game_active;
    logic [3:0] credits;
    logic [7:0] time_bcd;
    logic [3:0] score_player;
    logic [3:0] score_saucer;
    logic       extended;
    logic       invert;

    int total = 0;
    int bad   = 0;

    cs_game_sequencer dut (
        .clk_i        (clk_i),
        .res_n_i      (res_n_i),
        .vsync        (vsync),
        .coin         (coin),
        .start        (start),
        .hit_player   (hit_player),
        .hit_saucer   (hit_saucer),
        .game_active  (game_active),
        .credits      (credits),
        .time_bcd     (time_bcd),
        .score_player (score_player),
        .score_saucer (score_saucer),
        .extended     (extended),
        .invert       (invert)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            vsync = 1'b1;
            tick();
            vsync = 1'b0;
            tick();
        end
    endtask

    task automatic coin_pulse();
        coin = 1'b1;
        tick();
        coin = 1'b0;
        tick();
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic hit(input logic p, input logic s);
        hit_player = p;
        hit_saucer = s;
        tick();
        hit_player = 1'b0;
        hit_saucer = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        res_n_i = 1'b0;
        tick();
        res_n_i = 1'b1;
        tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_active",   8'(game_active),  8'd0);
        check("rst_credits",  8'(credits),      8'd0);
        check("rst_time",     time_bcd,         8'h00);
        check("rst_score_p",  8'(score_player), 8'd0);
        check("rst_score_s",  8'(score_saucer), 8'd0);
        check("rst_extended", 8'(extended),     8'd0);
        check("rst_invert",   8'(invert),       8'd0);
        res_n_i = 1'b1;
        tick();

        // Hits outside PLAY are ignored
        hit(1'b1, 1'b1);
        check("attract_hit_p", 8'(score_player), 8'd0);
        check("attract_hit_s", 8'(score_saucer), 8'd0);

        // Credit saturation
        for (int i = 0; i < 11; i++) coin_pulse();
        check("coin_sat",        8'(credits),     8'd9);
        check("coin_sat_active", 8'(game_active), 8'd0);

        // One credit, start, first second
        do_reset();
        check("reset_credits", 8'(credits), 8'd0);
        coin_pulse();
        check("one_credit", 8'(credits), 8'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_active",   8'(game_active),  8'd1);
        check("start_credits",  8'(credits),      8'd0);
        check("start_time",     time_bcd,         8'h99);
        check("start_score_p",  8'(score_player), 8'd0);
        check("start_extended", 8'(extended),     8'd0);
        tick();
        frames(59);
        check("time_59_frames", time_bcd, 8'h99);
        frames(1);
        check("time_60_frames", time_bcd, 8'h98);

        // Scores 3/5, run down through 10 -> 09 -> 00
        for (int i = 0; i < 3; i++) hit(1'b1, 1'b1);
        for (int i = 0; i < 2; i++) hit(1'b0, 1'b1);
        check("score_p_3", 8'(score_player), 8'd3);
        check("score_s_5", 8'(score_saucer), 8'd5);
        frames(88 * 60);
        check("time_10", time_bcd, 8'h10);
        frames(60);
        check("time_09", time_bcd, 8'h09);
        frames(9 * 60);
        check("over_active",  8'(game_active),  8'd0);
        check("over_time",    time_bcd,         8'h00);
        check("over_score_p", 8'(score_player), 8'd3);
        check("over_score_s", 8'(score_saucer), 8'd5);

        // GAME_OVER holds for 180 frames and ignores start
        frames(179);
        coin_pulse();
        start_pulse();
        check("over_start_ignored", 8'(game_active), 8'd0);
        check("over_credits_kept",  8'(credits),     8'd1);
        frames(1);
        start_pulse();
        check("attract_restart",   8'(game_active),  8'd1);
        check("restart_credits",   8'(credits),      8'd0);
        check("restart_score_p",   8'(score_player), 8'd0);
        check("restart_score_s",   8'(score_saucer), 8'd0);
        check("restart_time",      time_bcd,         8'h99);

        // Extended play: 6/2 at 00
        for (int i = 0; i < 2; i++) hit(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) hit(1'b1, 1'b0);
        frames(99 * 60);
        check("ext_time",     time_bcd,         8'h99);
        check("ext_flag",     8'(extended),     8'd1);
        check("ext_invert99", 8'(invert),       8'd1);
        check("ext_active",   8'(game_active),  8'd1);
        check("ext_score_p",  8'(score_player), 8'd6);
        frames(60);
        check("ext_time98",   time_bcd,         8'h98);
        check("ext_invert98", 8'(invert),       8'd0);
        frames(60);
        check("ext_time97",   time_bcd,         8'h97);
        check("ext_invert97", 8'(invert),       8'd1);

        // Scores to 9/9, then simultaneous wrap
        for (int i = 0; i < 3; i++) hit(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) hit(1'b0, 1'b1);
        check("score_p_9", 8'(score_player), 8'd9);
        check("score_s_9", 8'(score_saucer), 8'd9);
        hit(1'b1, 1'b1);
        check("wrap_p", 8'(score_player), 8'd0);
        check("wrap_s", 8'(score_saucer), 8'd0);

        // Second 00 ends the game
        frames(97 * 60);
        check("ext_over_active", 8'(game_active), 8'd0);
        check("ext_over_time",   time_bcd,        8'h00);
        check("ext_over_invert", 8'(invert),      8'd0);

        // Coin and start together with zero credits
        do_reset();
        coin  = 1'b1;
        start = 1'b1;
        tick();
        coin  = 1'b0;
        start = 1'b0;
        check("coinstart_active",  8'(game_active), 8'd1);
        check("coinstart_credits", 8'(credits),     8'd0);
        tick();

        // Coin during PLAY, then reset mid-PLAY with coin/start held high
        coin  = 1'b1;
        start = 1'b1;
        tick();
        check("play_coin", 8'(credits), 8'd1);
        #1;
        res_n_i = 1'b0;
        #1;
        check("async_credits", 8'(credits),     8'd0);
        check("async_active",  8'(game_active), 8'd0);
        check("async_time",    time_bcd,        8'h00);
        tick();
        res_n_i = 1'b1;
        tick();
        tick();
        tick();
        check("release_credits", 8'(credits),     8'd0);
        check("release_active",  8'(game_active), 8'd0);
        coin = 1'b0;
        tick();
        coin_pulse();
        check("post_release_coin",  8'(credits),     8'd1);
        check("post_release_start", 8'(game_active), 8'd0);
        start = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
